aes128_iter_seq: RTL and testbench

AES128_ITER_SEQ -- requirements
Module: aes128_iter_seq

---
 rtl/aes128_iter_seq_if.sv | 27 ++
 rtl/aes128_iter_seq.sv | 255 +++++++++++++++++++++++++
 tb/tb_aes128_iter_seq.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/aes128_iter_seq_if.sv
// Key-load, block-request and result handshake bundle for aes128_iter_seq.
// Status outputs key_loaded and busy travel with the bundle.
interface aes128_iter_seq_if;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key;
  logic         key_loaded;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;

  modport master (
    output key_valid, key, in_valid, in_mode, in_data, out_ready,
    input  key_ready, key_loaded, in_ready, out_valid, out_data, out_err, busy
  );

  modport slave (
    input  key_valid, key, in_valid, in_mode, in_data, out_ready,
    output key_ready, key_loaded, in_ready, out_valid, out_data, out_err, busy
  );
endinterface

// File: rtl/aes128_iter_seq.sv
// Iterative AES-128 core: one round (or one round key) per cycle, 128-bit state
// with FIPS byte 0 at bits [7:0]. Round keys rk0..rk10 are held in registers.
module aes128_iter_seq #(
  parameter bit DEC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  aes128_iter_seq_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StKeyExp, StEnc, StDec, StDone} state_e;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic         key_loaded_q, key_loaded_d;
  logic         out_err_q, out_err_d;
  logic [127:0] rk_q [11];
  logic         rk_we;
  logic [3:0]   rk_widx;
  logic [127:0] rk_wdata;

  logic         key_ready, in_ready, out_valid, busy;
  logic [127:0] rk_prev, rk_next;
  logic [31:0]  kw_t, kw0, kw1, kw2, kw3;
  logic [127:0] enc_sr, enc_next, dec_ark, dec_next;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (exponent bits 1..7 set); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, sq;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = sbox(w[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Byte (row r, column c) lives at index r + 4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*src) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] mix_coef(input int k, input logic inv);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(mix_coef((j - r + 4) % 4, inv), s[8*(j + 4*c) +: 8]);
        end
        o[8*(r + 4*c) +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next round key from rk[rnd-1]; word 3 sits in bits [127:96].
  always_comb begin
    rk_prev = rk_q[rnd_q - 4'd1];
    kw_t    = sub_word({rk_prev[103:96], rk_prev[127:104]}) ^ {24'h0, rcon(rnd_q)};
    kw0     = rk_prev[31:0]   ^ kw_t;
    kw1     = rk_prev[63:32]  ^ kw0;
    kw2     = rk_prev[95:64]  ^ kw1;
    kw3     = rk_prev[127:96] ^ kw2;
    rk_next = {kw3, kw2, kw1, kw0};
  end

  always_comb begin
    enc_sr   = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
    enc_next = ((rnd_q == 4'd10) ? enc_sr : mix_cols(enc_sr, 1'b0)) ^ rk_q[rnd_q];
    dec_ark  = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk_q[rnd_q];
    dec_next = (rnd_q == 4'd0) ? dec_ark : mix_cols(dec_ark, 1'b1);
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state. A key offer wins over a simultaneous block request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.key_valid) begin
          state_d = StKeyExp;
        end else if (bus.in_valid && key_loaded_q) begin
          if (!bus.in_mode) state_d = StEnc;
          else              state_d = DEC_EN ? StDec : StDone;
        end
      end
      StKeyExp: if (rnd_q == 4'd10) state_d = StIdle;
      StEnc:    if (rnd_q == 4'd10) state_d = StDone;
      StDec:    if (rnd_q == 4'd0)  state_d = StDone;
      StDone:   if (bus.out_ready)  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    key_ready = (state_q == StIdle);
    in_ready  = (state_q == StIdle) && key_loaded_q && !bus.key_valid;
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign bus.key_ready  = key_ready;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.busy       = busy;
  assign bus.out_data   = st_q;
  assign bus.out_err    = out_err_q;
  assign bus.key_loaded = key_loaded_q;

  always_comb begin
    st_d         = st_q;
    rnd_d        = rnd_q;
    key_loaded_d = key_loaded_q;
    out_err_d    = out_err_q;
    rk_we        = 1'b0;
    rk_widx      = rnd_q;
    rk_wdata     = rk_next;
    case (state_q)
      StIdle: begin
        if (bus.key_valid) begin
          rk_we        = 1'b1;
          rk_widx      = 4'd0;
          rk_wdata     = bus.key;
          key_loaded_d = 1'b0;
          rnd_d        = 4'd1;
        end else if (bus.in_valid && key_loaded_q) begin
          if (!bus.in_mode) begin
            st_d  = bus.in_data ^ rk_q[0];
            rnd_d = 4'd1;
          end else if (DEC_EN) begin
            st_d  = bus.in_data ^ rk_q[10];
            rnd_d = 4'd9;
          end else begin
            st_d      = bus.in_data;
            out_err_d = 1'b1;
          end
        end
      end
      StKeyExp: begin
        rk_we = 1'b1;
        if (rnd_q == 4'd10) key_loaded_d = 1'b1;
        else                rnd_d        = rnd_q + 4'd1;
      end
      StEnc: begin
        st_d = enc_next;
        if (rnd_q != 4'd10) rnd_d = rnd_q + 4'd1;
      end
      StDec: begin
        st_d = dec_next;
        if (rnd_q != 4'd0) rnd_d = rnd_q - 4'd1;
      end
      StDone: if (bus.out_ready) out_err_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= '0;
      rnd_q        <= '0;
      key_loaded_q <= 1'b0;
      out_err_q    <= 1'b0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
    end else begin
      st_q         <= st_d;
      rnd_q        <= rnd_d;
      key_loaded_q <= key_loaded_d;
      out_err_q    <= out_err_d;
      if (rk_we) rk_q[rk_widx] <= rk_wdata;
    end
  end

endmodule

// File: tb/tb_aes128_iter_seq.sv
// Directed FIPS-197 vectors against two instances (DEC_EN=1 and DEC_EN=0) driven in lockstep.
module tb_aes128_iter_seq;

  localparam logic [127:0] KeyA  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PtA   = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CtA   = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] Rk10A = 128'hc5302b4d8ba707f3174a94e37f1d1113;
  localparam logic [127:0] KeyB  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PtB   = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CtB   = 128'h320b6a19978511dcfb09dc021d842539;
  localparam logic [127:0] Rk10B = 128'ha60c63b6c80c3fe18925eec9a8f914d0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         key_valid = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b0;
  logic [127:0] key = '0, in_data = '0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes128_iter_seq_if bus ();
  aes128_iter_seq_if bus_nd ();

  assign bus.key_valid    = key_valid;
  assign bus.key          = key;
  assign bus.in_valid     = in_valid;
  assign bus.in_mode      = in_mode;
  assign bus.in_data      = in_data;
  assign bus.out_ready    = out_ready;
  assign bus_nd.key_valid = key_valid;
  assign bus_nd.key       = key;
  assign bus_nd.in_valid  = in_valid;
  assign bus_nd.in_mode   = in_mode;
  assign bus_nd.in_data   = in_data;
  assign bus_nd.out_ready = out_ready;

  aes128_iter_seq #(.DEC_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  aes128_iter_seq #(.DEC_EN(1'b0)) dut_nd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nd)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] rk10);
    int n;
    key_valid = 1'b1;
    key       = k;
    tick();
    key_valid = 1'b0;
    key       = ~k;
    check_eq("kx_busy", 128'(bus.busy), 128'(1));
    check_eq("kx_key_ready", 128'(bus.key_ready), 128'(0));
    n = 0;
    while (!bus.key_loaded && n < 30) begin
      tick();
      n++;
    end
    check_eq("kx_latency", 128'(n), 128'(10));
    check_eq("kx_rk10", dut.rk_q[10], rk10);
    check_eq("kx_idle_ready", 128'(bus.key_ready), 128'(1));
  endtask

  task automatic run_block(input logic mode, input logic [127:0] din, input logic [127:0] exp,
                           input bit hold);
    int n;
    int nd_lat;
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = din;
    n = 0;
    while (!bus.in_ready && n < 30) begin
      tick();
      n++;
    end
    check_eq("blk_in_ready", 128'(bus.in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    in_mode  = ~mode;
    in_data  = ~din;
    n      = 0;
    nd_lat = bus_nd.out_valid ? 0 : -1;
    while (!bus.out_valid && n < 30) begin
      tick();
      n++;
      if (nd_lat < 0 && bus_nd.out_valid) nd_lat = n;
    end
    check_eq(mode ? "dec_latency" : "enc_latency", 128'(n), 128'(10));
    check_eq(mode ? "dec_data" : "enc_data", bus.out_data, exp);
    check_eq(mode ? "dec_err" : "enc_err", 128'(bus.out_err), 128'(0));
    check_eq("nd_latency", 128'(nd_lat), mode ? 128'(0) : 128'(10));
    check_eq("nd_data", bus_nd.out_data, mode ? din : exp);
    check_eq("nd_err", 128'(bus_nd.out_err), 128'(mode));
    if (hold) begin
      in_valid = 1'b1;
      in_mode  = 1'b0;
      in_data  = PtB;
      for (int i = 0; i < 5; i++) begin
        tick();
        check_eq("hold_valid", 128'(bus.out_valid), 128'(1));
        check_eq("hold_data", bus.out_data, exp);
        check_eq("hold_no_accept", 128'(bus.in_ready), 128'(0));
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("ack_valid", 128'(bus.out_valid), 128'(0));
    check_eq("ack_busy", 128'(bus.busy), 128'(0));
    check_eq("ack_nd_err", 128'(bus_nd.out_err), 128'(0));
    check_eq("ack_in_ready", 128'(bus.in_ready), 128'(1));
  endtask

  initial begin
    int  n;
    bit  seen;

    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_busy", 128'(bus.busy), 128'(0));
    check_eq("rst_key_loaded", 128'(bus.key_loaded), 128'(0));
    check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check_eq("rst_out_data", bus.out_data, 128'(0));
    check_eq("rst_out_err", 128'(bus.out_err), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_key_ready", 128'(bus.key_ready), 128'(1));
    check_eq("post_rst_in_ready", 128'(bus.in_ready), 128'(0));

    load_key(KeyA, Rk10A);
    run_block(1'b0, PtA, CtA, 1'b1);
    run_block(1'b1, CtA, PtA, 1'b0);

    // Key and block offered together: key wins, block stalls through expansion.
    key_valid = 1'b1;
    key       = KeyA;
    in_valid  = 1'b1;
    in_mode   = 1'b0;
    in_data   = PtA;
    #1;
    check_eq("both_in_ready", 128'(bus.in_ready), 128'(0));
    check_eq("both_key_ready", 128'(bus.key_ready), 128'(1));
    tick();
    key_valid = 1'b0;
    check_eq("both_key_taken", 128'(bus.key_loaded), 128'(0));
    n    = 0;
    seen = 1'b0;
    while (!bus.key_loaded && n < 30) begin
      if (bus.in_ready || bus.out_valid) seen = 1'b1;
      tick();
      n++;
    end
    check_eq("both_kx_latency", 128'(n), 128'(10));
    check_eq("both_stalled", 128'(seen), 128'(0));
    run_block(1'b0, PtA, CtA, 1'b0);

    // Reset during encryption round 5.
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = PtA;
    tick();
    in_valid = 1'b0;
    check_eq("mid_busy", 128'(bus.busy), 128'(1));
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 128'(bus.busy), 128'(0));
    check_eq("mid_rst_key_loaded", 128'(bus.key_loaded), 128'(0));
    check_eq("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
    check_eq("mid_rst_out_data", bus.out_data, 128'(0));
    check_eq("mid_rst_rk10", dut.rk_q[10], 128'(0));
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (bus.out_valid || bus.in_ready || bus.busy) seen = 1'b1;
    end
    in_valid = 1'b0;
    check_eq("mid_rst_quiet", 128'(seen), 128'(0));

    load_key(KeyB, Rk10B);
    run_block(1'b0, PtB, CtB, 1'b0);
    run_block(1'b1, CtB, PtB, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
